// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, fixed one-cycle-latency imem requests, and a small
// {pc, instr} FIFO toward decode. Optional macro FETCH_MISALIGN_TRAP_EN adds a HALT trap.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_re,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            f_valid,
    output logic [XLEN-1:0] f_instr,
    output logic [XLEN-1:0] f_pc,
    input  logic            d_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {FETCH, STALL, HALT} state_t;
`else
    typedef enum logic [1:0] {FETCH, STALL} state_t;
`endif

    state_t          state, state_next;
    logic [XLEN-1:0] pc;
    logic            pending;
    logic [XLEN-1:0] pending_pc;
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_mem    [BUF_DEPTH];
    logic [XLEN-1:0] instr_mem [BUF_DEPTH];

    logic            pop, push, credit;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] target_pc;

    assign pop       = f_valid & d_ready;
    assign push      = pending & ~redirect;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, pop};
    assign credit    = occupancy < DEPTH_C;
    assign target_pc = redirect_pc & ~(XLEN'(3));

    assign imem_re   = (state == FETCH) & credit & ~redirect & ~reset;
    assign imem_addr = pc;

    // Outputs are gated so the storage itself never needs a reset.
    assign f_valid = (count != '0);
    assign f_pc    = f_valid ? pc_mem[rptr]    : '0;
    assign f_instr = f_valid ? instr_mem[rptr] : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    logic fault;
    assign misaligned  = redirect & (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (misaligned) begin
            fault <= 1'b1;
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (!credit) state_next = STALL;
            STALL:   if (credit)  state_next = FETCH;
            default: state_next = state;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (state == HALT) begin
            state_next = HALT;
        end else if (redirect) begin
            state_next = misaligned ? HALT : FETCH;
        end
`else
        if (redirect) begin
            state_next = FETCH;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
        end else begin
            state <= state_next;
            if (redirect) begin
                // Flush wins over everything: the in-flight response and any pop are dropped.
                pc      <= target_pc;
                pending <= 1'b0;
                wptr    <= '0;
                rptr    <= '0;
                count   <= '0;
            end else begin
                pending <= imem_re;
                if (imem_re) begin
                    pending_pc <= pc;
                    pc         <= pc + XLEN'(4);
                end
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: FIFO storage has no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wptr]    <= pending_pc;
            instr_mem[wptr] <= imem_rdata;
        end
    end

endmodule
